fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, address of first instruction word after reset.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_addr  out  16  byte address of requested program word.
REQ-005 mem_rd  out  1  one-cycle read request strobe.
REQ-006 mem_rdata  in  16  program word, valid only while mem_ack=1.
REQ-007 mem_ack  in  1  read data return; arrives 1 or more cycles after mem_rd.
REQ-008 instruction  out  16  opcode word delivered to decode.
REQ-009 instruction_1  out  16  first extension word (zero if none).
REQ-010 instruction_2  out  16  second extension word (zero if none).
REQ-011 instr_pc  out  16  byte address of delivered opcode word.
REQ-012 instr_valid  out  1  instruction bundle valid.
REQ-013 instr_ready  in  1  decode accepts bundle when instr_valid=1.
REQ-014 redirect  in  1  take jump for the bundle being accepted.
REQ-015 redirect_offset  in  10  signed word offset of the jump.

Function
REQ-016 States SHALL be REQ_OP, WAIT_OP, REQ_X1, WAIT_X1, REQ_X2, WAIT_X2, HOLD.
REQ-017 REQ_* states SHALL drive mem_rd=1 for exactly one cycle with mem_addr=fetch_pc, then enter matching WAIT_*; mem_rd=0 in all other states.
REQ-018 At most one read SHALL be outstanding; mem_ack outside a WAIT_* state SHALL be ignored.
REQ-019 On mem_ack in any WAIT_* state the word SHALL be captured into the matching output register and fetch_pc SHALL advance by 2 (16-bit wrap, 16'hFFFE+2=16'h0000).
REQ-020 Extension count from opcode word w: w[15:12]>=4 (double-op): +1 if w[5:4]==01, +1 if w[5:4]==11 and w[11:8]==0, +1 if w[7]==1; w[15:12]==1 (single-op): +1 if w[5:4]==01, or w[5:4]==11 and w[3:0]==0; all other opcodes: 0.
REQ-021 After WAIT_OP ack: count 0 -> HOLD; else REQ_X1. After WAIT_X1 ack: count 2 -> REQ_X2; else HOLD. After WAIT_X2 ack -> HOLD.
REQ-022 On entering REQ_OP, instruction_1 and instruction_2 SHALL be cleared to 0 and instr_pc SHALL load fetch_pc.
REQ-023 instr_valid SHALL be 1 exactly in HOLD; outputs SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 Handshake: HOLD with instr_ready=1 SHALL go to REQ_OP next cycle; minimum issue interval is 3 cycles per 1-word instruction with 1-cycle ack.
REQ-025 redirect SHALL be sampled only when instr_valid=1 and instr_ready=1; then fetch_pc SHALL load instr_pc + 2 + (sign_extend(redirect_offset) << 1), truncated to 16 bits.
REQ-026 redirect outside an accepted handshake SHALL have no effect.
REQ-027 Bit 0 of fetch_pc SHALL always be 0.

Reset
REQ-028 rst=1 SHALL immediately force state REQ_OP, fetch_pc=RESET_PC, mem_rd=0, instr_valid=0, instruction/instruction_1/instruction_2/instr_pc=0, regardless of any outstanding read.
REQ-029 mem_ack arriving after rst deassertion for a read issued before rst SHALL be ignored; the first read after reset is issued in the first cycle with rst=0, at RESET_PC.

Verification
REQ-030 Reset, mem[0]=16'h5203 (ADD R2,R3, register mode), ack latency 1, ready=1 -> mem_rd at addr 0, instr_valid with instruction=16'h5203, instruction_1=0, instr_pc=0; next fetch addr 2.
REQ-031 mem[2]=16'h4090 (As=01, Ad=1), mem[4]=16'h0010, mem[6]=16'h0020 -> bundle 4090/0010/0020, instr_pc=2; next fetch addr 8.
REQ-032 Bundle 16'h3C05 at instr_pc=16'h0010 accepted with redirect=1, offset=10'h005 -> next mem_addr=16'h001C; repeat with offset=10'h3FF -> 16'h0010.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> outputs stable, no mem_rd; ready=1 -> one mem_rd next cycle.
REQ-034 rst pulsed during WAIT_X1 with late mem_ack 2 cycles after deassert -> late ack ignored, fetch restarts at RESET_PC, instr_valid low until new bundle.
REQ-035 fetch_pc=16'hFFFE, 1-word instruction -> next fetch at 16'h0000.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: groups the program-memory read port and the decode-side
// instruction bundle handshake of the fetch unit.
//   master : the fetch unit (drives memory requests and the bundle)
//   slave  : the environment (program memory plus decode stage)
// Memory side : mem_addr, mem_rd (out); mem_rdata, mem_ack (in)
// Decode side : instruction, instruction_1, instruction_2, instr_pc,
//               instr_valid (out); instr_ready, redirect, redirect_offset (in)
`timescale 1ns/1ps
interface fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction;
    logic [15:0] instruction_1;
    logic [15:0] instruction_2;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [9:0]  redirect_offset;

    modport master (
        output mem_addr, mem_rd, instruction, instruction_1, instruction_2,
               instr_pc, instr_valid,
        input  mem_rdata, mem_ack, instr_ready, redirect, redirect_offset
    );

    modport slave (
        input  mem_addr, mem_rd, instruction, instruction_1, instruction_2,
               instr_pc, instr_valid,
        output mem_rdata, mem_ack, instr_ready, redirect, redirect_offset
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction bundle (opcode word plus up to two
// extension words) from a 16-bit program memory, one outstanding read at a
// time, and presents it to decode with a valid/ready handshake. Decode can
// redirect the fetch stream with a signed word offset relative to the
// accepted opcode.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_if.master -- memory read port and decode bundle handshake
// Parameter:
//   RESET_PC : byte address of the first opcode fetched after reset
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    typedef enum logic [2:0] {
        REQ_OP  = 3'd0,
        WAIT_OP = 3'd1,
        REQ_X1  = 3'd2,
        WAIT_X1 = 3'd3,
        REQ_X2  = 3'd4,
        WAIT_X2 = 3'd5,
        HOLD    = 3'd6
    } state_t;

    // Program words are 16-bit aligned, so the low address bit is forced clear.
    localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

    // Number of extension words that follow an opcode word.
    function automatic logic [1:0] ext_words(input logic [15:0] w);
        logic [1:0] n;
        n = 2'd0;
        if (w[15:12] >= 4'd4) begin
            // Double-operand: source extension, then destination extension.
            if ((w[5:4] == 2'b01) || ((w[5:4] == 2'b11) && (w[11:8] == 4'd0))) begin
                n = 2'd1;
            end else begin
                n = 2'd0;
            end
            if (w[7]) begin
                n = n + 2'd1;
            end else begin
                n = n;
            end
        end else if (w[15:12] == 4'd1) begin
            // Single-operand: at most one extension word.
            if ((w[5:4] == 2'b01) || ((w[5:4] == 2'b11) && (w[3:0] == 4'd0))) begin
                n = 2'd1;
            end else begin
                n = 2'd0;
            end
        end else begin
            n = 2'd0;
        end
        return n;
    endfunction

    state_t      state_r;
    logic [15:0] fetch_pc_r;
    logic [15:0] instruction_r;
    logic [15:0] instruction_1_r;
    logic [15:0] instruction_2_r;
    logic [15:0] instr_pc_r;
    logic [1:0]  ext_cnt_r;
    logic        mem_rd_r;
    logic        instr_valid_r;

    logic [1:0]  op_ext_s;
    logic [15:0] redirect_target_s;
    logic [15:0] pc_next_s;

    // Extension count of the word currently returning from memory.
    assign op_ext_s = ext_words(bus.mem_rdata);

    // Jump target: word after the opcode plus the sign-extended word offset.
    assign redirect_target_s = instr_pc_r + 16'd2
                             + {{5{bus.redirect_offset[9]}}, bus.redirect_offset, 1'b0};

    // Sequential advance by one word (wraps naturally at 16 bits).
    assign pc_next_s = fetch_pc_r + 16'd2;

    // mem_rd_r comes out of reset set because the FSM restarts in REQ_OP and
    // must request in the very first cycle after release; gating with rst
    // keeps the strobe low while reset is held.
    assign bus.mem_rd        = mem_rd_r & ~rst;
    assign bus.mem_addr      = fetch_pc_r;
    assign bus.instruction   = instruction_r;
    assign bus.instruction_1 = instruction_1_r;
    assign bus.instruction_2 = instruction_2_r;
    assign bus.instr_pc      = instr_pc_r;
    assign bus.instr_valid   = instr_valid_r;

    // Fetch FSM with registered memory strobe, bundle registers and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= REQ_OP;
            fetch_pc_r      <= RESET_PC_ALIGNED;
            instruction_r   <= 16'h0000;
            instruction_1_r <= 16'h0000;
            instruction_2_r <= 16'h0000;
            instr_pc_r      <= 16'h0000;
            ext_cnt_r       <= 2'd0;
            mem_rd_r        <= 1'b1;
            instr_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                REQ_OP: begin
                    // New bundle starts: stale extensions cleared, pc captured.
                    instruction_1_r <= 16'h0000;
                    instruction_2_r <= 16'h0000;
                    instr_pc_r      <= fetch_pc_r;
                    mem_rd_r        <= 1'b0;
                    state_r         <= WAIT_OP;
                end
                WAIT_OP: begin
                    if (bus.mem_ack) begin
                        instruction_r <= bus.mem_rdata;
                        ext_cnt_r     <= op_ext_s;
                        fetch_pc_r    <= pc_next_s;
                        if (op_ext_s == 2'd0) begin
                            instr_valid_r <= 1'b1;
                            state_r       <= HOLD;
                        end else begin
                            mem_rd_r <= 1'b1;
                            state_r  <= REQ_X1;
                        end
                    end else begin
                        state_r <= WAIT_OP;
                    end
                end
                REQ_X1: begin
                    mem_rd_r <= 1'b0;
                    state_r  <= WAIT_X1;
                end
                WAIT_X1: begin
                    if (bus.mem_ack) begin
                        instruction_1_r <= bus.mem_rdata;
                        fetch_pc_r      <= pc_next_s;
                        if (ext_cnt_r == 2'd2) begin
                            mem_rd_r <= 1'b1;
                            state_r  <= REQ_X2;
                        end else begin
                            instr_valid_r <= 1'b1;
                            state_r       <= HOLD;
                        end
                    end else begin
                        state_r <= WAIT_X1;
                    end
                end
                REQ_X2: begin
                    mem_rd_r <= 1'b0;
                    state_r  <= WAIT_X2;
                end
                WAIT_X2: begin
                    if (bus.mem_ack) begin
                        instruction_2_r <= bus.mem_rdata;
                        fetch_pc_r      <= pc_next_s;
                        instr_valid_r   <= 1'b1;
                        state_r         <= HOLD;
                    end else begin
                        state_r <= WAIT_X2;
                    end
                end
                HOLD: begin
                    // Bundle stays frozen until decode takes it; redirect only
                    // matters in the accepting cycle.
                    if (bus.instr_ready) begin
                        instr_valid_r <= 1'b0;
                        mem_rd_r      <= 1'b1;
                        state_r       <= REQ_OP;
                        if (bus.redirect) begin
                            fetch_pc_r <= redirect_target_s;
                        end else begin
                            fetch_pc_r <= fetch_pc_r;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    // Unused encoding: restart a clean opcode fetch.
                    instr_valid_r <= 1'b0;
                    mem_rd_r      <= 1'b1;
                    state_r       <= REQ_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_if bus();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic [15:0] x1;
        logic [15:0] x2;
        logic [15:0] pc;
    } bundle_t;

    typedef struct {
        logic       r;
        logic [9:0] o;
    } dir_t;

    logic [15:0] mem [0:32767];
    bundle_t     exp_q[$];
    logic [15:0] addr_q[$];
    dir_t        dir_q[$];

    logic [15:0] model_cur_pc;
    logic [15:0] model_next_seq;

    int total = 0;
    int bad   = 0;
    int seen  = 0;

    int ready_mode = 0;   // 0: always ready, 1: random, 2: never
    int redir_pct  = 0;
    int lat_max    = 1;
    int inject     = 0;   // counts down to a stale ack with no read behind it

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Extension words by the encoding rules, as a count of qualifying fields.
    function automatic int ext_of(input logic [15:0] w);
        int cls;
        int as_f;
        cls  = int'(w[15:12]);
        as_f = int'(w[5:4]);
        if (cls >= 4)
            return ((as_f == 1) ? 1 : 0)
                 + ((as_f == 3 && w[11:8] == 4'd0) ? 1 : 0)
                 + (w[7] ? 1 : 0);
        if (cls == 1)
            return ((as_f == 1) || (as_f == 3 && w[3:0] == 4'd0)) ? 1 : 0;
        return 0;
    endfunction

    // Expect the bundle that starts at pc and the reads that fetch it.
    task automatic push_at(input logic [15:0] pc);
        bundle_t     b;
        int          n;
        logic [15:0] a1;
        logic [15:0] a2;
        a1   = pc + 16'd2;
        a2   = pc + 16'd4;
        n    = ext_of(mem[pc[15:1]]);
        b.pc = pc;
        b.op = mem[pc[15:1]];
        b.x1 = (n >= 1) ? mem[a1[15:1]] : 16'h0000;
        b.x2 = (n == 2) ? mem[a2[15:1]] : 16'h0000;
        exp_q.push_back(b);
        addr_q.push_back(pc);
        if (n >= 1) addr_q.push_back(a1);
        if (n == 2) addr_q.push_back(a2);
        model_cur_pc   = pc;
        model_next_seq = pc + 16'(2 * (n + 1));
    endtask

    task automatic accept(input logic redir, input logic [9:0] off);
        int so;
        so = int'(off);
        if (off[9]) so = so - 1024;
        if (redir) push_at(model_cur_pc + 16'd2 + 16'(so * 2));
        else       push_at(model_next_seq);
    endtask

    // Memory responder: checks each request, answers after 1..lat_max cycles.
    initial begin
        int          pend;
        logic [15:0] pend_addr;
        pend = 0;
        pend_addr = 16'h0000;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #3;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'($urandom);
            if (rst) begin
                pend = 0;
            end else begin
                if (inject > 0) begin
                    inject--;
                    if (inject == 0) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = 16'hDEAD;
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem[pend_addr[15:1]];
                    end
                end
                if (bus.mem_rd) begin
                    chk("single_outstanding", 16'(pend), 16'd0);
                    chk("no_rd_while_valid", 16'(bus.instr_valid), 16'd0);
                    if (addr_q.size() == 0) chk("unexpected_rd_addr", bus.mem_addr, 16'hXXXX);
                    else chk("mem_addr", bus.mem_addr, addr_q.pop_front());
                    pend_addr = bus.mem_addr;
                    pend = int'($urandom_range(lat_max, 1));
                end
            end
        end
    end

    // Decode driver: chooses ready/redirect; an accepted bundle feeds the model.
    initial begin
        dir_t d;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_offset = 10'd0;
        forever begin
            @(posedge clk);
            #4;
            case (ready_mode)
                0:       bus.instr_ready = 1'b1;
                1:       bus.instr_ready = ($urandom_range(3, 0) != 0);
                default: bus.instr_ready = 1'b0;
            endcase
            bus.redirect        = ($urandom_range(99, 0) < redir_pct);
            bus.redirect_offset = 10'($urandom);
            if (!rst && bus.instr_valid && bus.instr_ready) begin
                if (dir_q.size() > 0) begin
                    d = dir_q.pop_front();
                    bus.redirect        = d.r;
                    bus.redirect_offset = d.o;
                end
                accept(bus.redirect, bus.redirect_offset);
            end
        end
    end

    // Monitor: compares each new bundle, and held bundles for stability.
    initial begin
        bit      have;
        bundle_t e;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0;
            end else if (bus.instr_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bundle", bus.instruction, 16'hXXXX);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instruction", bus.instruction, e.op);
                        chk("instruction_1", bus.instruction_1, e.x1);
                        chk("instruction_2", bus.instruction_2, e.x2);
                        chk("instr_pc", bus.instr_pc, e.pc);
                    end
                    have = 1'b1;
                    seen++;
                end else begin
                    chk("hold_instruction", bus.instruction, e.op);
                    chk("hold_instruction_1", bus.instruction_1, e.x1);
                    chk("hold_instruction_2", bus.instruction_2, e.x2);
                    chk("hold_instr_pc", bus.instr_pc, e.pc);
                end
                if (bus.instr_ready) have = 1'b0;
            end else begin
                have = 1'b0;
            end
        end
    end

    initial begin
        bit found;
        int seen0;
        rst = 1'b1;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h5203;  // 0x0000: ADD R2,R3, no extension
        mem[1]     = 16'h4090;  // 0x0002: two extensions
        mem[2]     = 16'h0010;
        mem[3]     = 16'h0020;
        mem[4]     = 16'h3C03;  // 0x0008: jump class
        mem[8]     = 16'h3C05;  // 0x0010
        mem[14]    = 16'h3C00;  // 0x001C
        mem[32]    = 16'h4010;  // 0x0040: one extension
        mem[32767] = 16'h4302;  // 0xFFFE: no extension
        #2;
        push_at(16'h0000);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_rd", 16'(bus.mem_rd), 16'd0);
        chk("rst_instr_valid", 16'(bus.instr_valid), 16'd0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_instruction", bus.instruction, 16'h0000);
        chk("rst_instr_pc", bus.instr_pc, 16'h0000);

        // Acceptance order: 0, 2, 8, 10, 1C, 10, 10, FFFE, 0, 2, 8 -> 40.
        dir_q.push_back('{1'b0, 10'h000});
        dir_q.push_back('{1'b0, 10'h000});
        dir_q.push_back('{1'b1, 10'h003});
        dir_q.push_back('{1'b1, 10'h005});
        dir_q.push_back('{1'b1, 10'h3F9});
        dir_q.push_back('{1'b1, 10'h3FF});
        dir_q.push_back('{1'b1, 10'h3F6});
        dir_q.push_back('{1'b0, 10'h000});
        dir_q.push_back('{1'b0, 10'h000});
        dir_q.push_back('{1'b0, 10'h000});
        dir_q.push_back('{1'b1, 10'h01B});

        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("first_rd_after_rst", 16'(bus.mem_rd), 16'd1);

        // Wait for the extension request of the bundle at 0x0040.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clk);
            #2;
            if (bus.mem_rd && bus.mem_addr == 16'h0042) found = 1'b1;
        end
        chk("reached_x1_fetch", 16'(found), 16'd1);

        // Reset in the middle of the extension wait.
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_instr_valid", 16'(bus.instr_valid), 16'd0);
        chk("arst_mem_rd", 16'(bus.mem_rd), 16'd0);
        chk("arst_instruction_1", bus.instruction_1, 16'h0000);
        chk("arst_mem_addr", bus.mem_addr, 16'h0000);
        exp_q.delete();
        addr_q.delete();
        dir_q.delete();
        push_at(16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        inject = 3;
        #4 chk("valid_low_c0", 16'(bus.instr_valid), 16'd0);
        @(posedge clk);
        #5 chk("valid_low_c1", 16'(bus.instr_valid), 16'd0);

        // Back-pressure: hold a bundle for 5 cycles, then release it.
        ready_mode = 2;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #5;
            if (bus.instr_valid) found = 1'b1;
        end
        chk("hold_reached", 16'(found), 16'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #5 chk("hold_no_rd", 16'(bus.mem_rd), 16'd0);
        end
        ready_mode = 0;
        @(posedge clk);
        #5 chk("ready_cycle_no_rd", 16'(bus.mem_rd), 16'd0);
        @(posedge clk);
        #2 chk("rd_after_accept", 16'(bus.mem_rd), 16'd1);

        // Randomized traffic: random ready, redirects and latency.
        ready_mode = 1;
        redir_pct  = 20;
        lat_max    = 4;
        seen0      = seen;
        repeat (3000) @(posedge clk);
        chk("bundle_progress", ((seen - seen0) >= 100) ? 16'd1 : 16'd0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
